// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage: B-type condition codes
// and the legality check used by the comparator.
package branch_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // 010 and 011 are the only encodings with no B-type meaning.
  function automatic logic is_legal_branch(input logic [2:0] func3);
    return !((func3 == 3'b010) || (func3 == 3'b011));
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle between issue, the branch resolution stage and fetch
// redirect; master drives branches in and consumes results.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [2:0]       func3;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_redirect_pc;
  logic             out_mispredict;
  logic             out_illegal;
  logic             out_misaligned;
  logic [CNT_W-1:0] taken_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output in_valid, rs1, rs2, func3, pc, imm, pred_taken, flush, out_ready,
    input  in_ready, out_valid, out_taken, out_redirect_pc, out_mispredict,
           out_illegal, out_misaligned, taken_count, mispredict_count
  );

  modport slave (
    input  in_valid, rs1, rs2, func3, pc, imm, pred_taken, flush, out_ready,
    output in_ready, out_valid, out_taken, out_redirect_pc, out_mispredict,
           out_illegal, out_misaligned, taken_count, mispredict_count
  );

endinterface

// File: rtl/branch_cmp.sv
// Combinational B-type condition evaluator; illegal encodings never report
// a true condition.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  output logic            cond,
  output logic            illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = !is_legal_branch(func3);
    case (func3)
      BR_EQ:   cond = (rs1 == rs2);
      BR_NE:   cond = (rs1 != rs2);
      BR_LT:   cond = ($signed(rs1) <  $signed(rs2));
      BR_GE:   cond = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  cond = (rs1 <  rs2);
      BR_GEU:  cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: one-entry result register, redirect
// address selection, misprediction detection and saturating retire counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter int INSN_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  logic             w_cond;
  logic             w_illegal;
  logic             w_taken;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_fallthru;
  logic [XLEN-1:0]  w_redirect;
  logic             w_mispredict;
  logic             w_misaligned;

  logic             r_valid;
  logic             r_taken;
  logic [XLEN-1:0]  r_redirect;
  logic             r_mispredict;
  logic             r_illegal;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_misp_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             inc);
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      return cnt + CNT_W'(1);
    end
    return cnt;
  endfunction

  branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .func3  (bus.func3),
    .cond   (w_cond),
    .illegal(w_illegal)
  );

  assign w_taken      = w_cond && !w_illegal;
  assign w_target     = bus.pc + bus.imm;
  assign w_fallthru   = bus.pc + XLEN'(INSN_BYTES);
  assign w_redirect   = w_taken ? w_target : w_fallthru;
  assign w_mispredict = !w_illegal && (w_taken != bus.pred_taken);
  assign w_misaligned = w_taken && (w_target[1:0] != 2'b00);

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_in_fire    = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_out_fire   = r_valid && bus.out_ready && !bus.flush;

  // Flush wins over both a retiring result and a same-cycle new branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_redirect   <= '0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_valid      <= 1'b1;
      r_taken      <= w_taken;
      r_redirect   <= w_redirect;
      r_mispredict <= w_mispredict;
      r_illegal    <= w_illegal;
      r_misaligned <= w_misaligned;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  // Counters look only at the result leaving the register, never the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
      r_misp_cnt  <= '0;
    end else if (w_out_fire) begin
      r_taken_cnt <= sat_inc(r_taken_cnt, r_taken);
      r_misp_cnt  <= sat_inc(r_misp_cnt, r_mispredict);
    end
  end

  assign bus.out_valid        = r_valid;
  assign bus.out_taken        = r_taken;
  assign bus.out_redirect_pc  = r_redirect;
  assign bus.out_mispredict   = r_mispredict;
  assign bus.out_illegal      = r_illegal;
  assign bus.out_misaligned   = r_misaligned;
  assign bus.taken_count      = r_taken_cnt;
  assign bus.mispredict_count = r_misp_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=32, CNT_W=2): compare codes,
// backpressure, flush, wrap-around misalignment, saturation and async reset.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .XLEN      (XLEN),
    .CNT_W     (CNT_W),
    .INSN_BYTES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] f3, input logic [31:0] p,
                               input logic [31:0] im, input logic pt);
    bus.in_valid   = v;
    bus.rs1        = a;
    bus.rs2        = b;
    bus.func3      = f3;
    bus.pc         = p;
    bus.imm        = im;
    bus.pred_taken = pt;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, " out_taken"}, 64'(bus.out_taken), 64'd0);
    checkOutput({tag, " redirect"}, 64'(bus.out_redirect_pc), 64'd0);
    checkOutput({tag, " mispredict"}, 64'(bus.out_mispredict), 64'd0);
    checkOutput({tag, " illegal"}, 64'(bus.out_illegal), 64'd0);
    checkOutput({tag, " misaligned"}, 64'(bus.out_misaligned), 64'd0);
    checkOutput({tag, " taken_count"}, 64'(bus.taken_count), 64'd0);
    checkOutput({tag, " misp_count"}, 64'(bus.mispredict_count), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 1'b0);
    #2;
    checkAllZero("reset");
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // BLT -1 < 1 taken, predicted not taken
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'h100, 32'h20, 1'b0);
    tick();
    checkOutput("blt valid", 64'(bus.out_valid), 64'd1);
    checkOutput("blt taken", 64'(bus.out_taken), 64'd1);
    checkOutput("blt redirect", 64'(bus.out_redirect_pc), 64'h120);
    checkOutput("blt mispredict", 64'(bus.out_mispredict), 64'd1);
    checkOutput("blt misaligned", 64'(bus.out_misaligned), 64'd0);
    checkOutput("blt count before retire", 64'(bus.mispredict_count), 64'd0);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("blt misp_count", 64'(bus.mispredict_count), 64'd1);
    checkOutput("blt taken_count", 64'(bus.taken_count), 64'd1);
    checkOutput("blt drained", 64'(bus.out_valid), 64'd0);

    // BLTU 0xFFFFFFFF < 1 not taken
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b110, 32'h100, 32'h20, 1'b0);
    tick();
    checkOutput("bltu taken", 64'(bus.out_taken), 64'd0);
    checkOutput("bltu redirect", 64'(bus.out_redirect_pc), 64'h104);
    checkOutput("bltu mispredict", 64'(bus.out_mispredict), 64'd0);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("bltu taken_count", 64'(bus.taken_count), 64'd1);
    checkOutput("bltu misp_count", 64'(bus.mispredict_count), 64'd1);

    // Illegal func3=010 predicted taken
    applyStimulus(1'b1, 32'd5, 32'd5, 3'b010, 32'h200, 32'h8, 1'b1);
    tick();
    checkOutput("illegal flag", 64'(bus.out_illegal), 64'd1);
    checkOutput("illegal taken", 64'(bus.out_taken), 64'd0);
    checkOutput("illegal mispredict", 64'(bus.out_mispredict), 64'd0);
    checkOutput("illegal misaligned", 64'(bus.out_misaligned), 64'd0);
    checkOutput("illegal redirect", 64'(bus.out_redirect_pc), 64'h204);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("illegal taken_count", 64'(bus.taken_count), 64'd1);
    checkOutput("illegal misp_count", 64'(bus.mispredict_count), 64'd1);

    // Backpressure: A held 3 cycles while B waits, then B, C, D stream out
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'd3, 32'd3, 3'b000, 32'h300, 32'h10, 1'b1);
    tick();
    applyStimulus(1'b1, 32'd3, 32'd4, 3'b001, 32'h400, 32'h40, 1'b0);
    #1;
    checkOutput("bp in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp hold valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp hold redirect", 64'(bus.out_redirect_pc), 64'h310);
      checkOutput("bp hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkOutput("B redirect", 64'(bus.out_redirect_pc), 64'h440);
    checkOutput("B mispredict", 64'(bus.out_mispredict), 64'd1);
    checkOutput("A retired taken_count", 64'(bus.taken_count), 64'd2);
    checkOutput("A retired misp_count", 64'(bus.mispredict_count), 64'd1);
    applyStimulus(1'b1, 32'd5, 32'd3, 3'b100, 32'h500, 32'h8, 1'b1);
    tick();
    checkOutput("C redirect", 64'(bus.out_redirect_pc), 64'h504);
    checkOutput("C taken", 64'(bus.out_taken), 64'd0);
    checkOutput("C mispredict", 64'(bus.out_mispredict), 64'd1);
    checkOutput("B retired taken_count", 64'(bus.taken_count), 64'd3);
    checkOutput("B retired misp_count", 64'(bus.mispredict_count), 64'd2);
    applyStimulus(1'b1, 32'd1, 32'hFFFF_FFFF, 3'b111, 32'h600, 32'h8, 1'b0);
    tick();
    checkOutput("D redirect", 64'(bus.out_redirect_pc), 64'h604);
    checkOutput("D mispredict", 64'(bus.out_mispredict), 64'd0);
    checkOutput("C retired misp_count", 64'(bus.mispredict_count), 64'd3);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("D drained", 64'(bus.out_valid), 64'd0);
    checkOutput("D retired taken_count", 64'(bus.taken_count), 64'd3);

    // Asynchronous reset while a result is pending
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'd2, 32'd2, 3'b000, 32'h900, 32'h0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("pre-reset valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 64'(bus.in_ready), 64'd1);

    // Flush with pending result, out_ready high and a new branch offered
    applyStimulus(1'b1, 32'd7, 32'd7, 3'b000, 32'h700, 32'h4, 1'b0);
    tick();
    checkOutput("E pending valid", 64'(bus.out_valid), 64'd1);
    checkOutput("E mispredict", 64'(bus.out_mispredict), 64'd1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    applyStimulus(1'b1, 32'd1, 32'd1, 3'b000, 32'hA00, 32'h4, 1'b0);
    tick();
    checkOutput("flush valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush taken_count", 64'(bus.taken_count), 64'd0);
    checkOutput("flush misp_count", 64'(bus.mispredict_count), 64'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checkOutput("flush input discarded", 64'(bus.out_valid), 64'd0);

    // Target wraps past 2^32 and lands misaligned
    applyStimulus(1'b1, 32'd9, 32'd9, 3'b000, 32'hFFFF_FFF0, 32'h12, 1'b1);
    tick();
    checkOutput("wrap taken", 64'(bus.out_taken), 64'd1);
    checkOutput("wrap redirect", 64'(bus.out_redirect_pc), 64'h2);
    checkOutput("wrap misaligned", 64'(bus.out_misaligned), 64'd1);
    checkOutput("wrap mispredict", 64'(bus.out_mispredict), 64'd0);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("wrap taken_count", 64'(bus.taken_count), 64'd1);

    // Five more taken branches back to back: count saturates at 3
    applyStimulus(1'b1, 32'd1, 32'd1, 3'b000, 32'h800, 32'h10, 1'b1);
    tick();
    tick();
    checkOutput("sat taken_count 2", 64'(bus.taken_count), 64'd2);
    tick();
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    checkOutput("sat taken_count", 64'(bus.taken_count), 64'd3);
    checkOutput("sat misp_count", 64'(bus.mispredict_count), 64'd0);
    checkOutput("sat drained", 64'(bus.out_valid), 64'd0);

    // Reset mid-stream with a result in flight
    applyStimulus(1'b1, 32'd4, 32'd6, 3'b001, 32'hB00, 32'h20, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("final pending valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("final reset");
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("final in_ready", 64'(bus.in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered branch resolution stage for the execute pipeline.
- Accepts one conditional branch per handshake and evaluates the RV32/RV64 B-type condition (EQ/NE/LT/GE/LTU/GEU).
- Computes target and fall-through addresses, flags mispredictions against the fetch-stage prediction, and keeps saturating taken/mispredict counters for performance monitoring.
- Sits between the operand-read/issue stage and the fetch redirect logic.

Parameters:
- XLEN, 32, operand and address width (32 or 64).
- CNT_W, 16, width of each performance counter.
- INSN_BYTES, 4, fall-through increment added to pc.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input branch valid.
- in_ready  out  1  unit can accept input.
- rs1  in  XLEN  first source operand.
- rs2  in  XLEN  second source operand.
- func3  in  3  branch condition code.
- pc  in  XLEN  branch instruction address.
- imm  in  XLEN  sign-extended branch offset.
- pred_taken  in  1  fetch-stage prediction.
- flush  in  1  pipeline kill.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  branch condition true.
- out_redirect_pc  out  XLEN  taken ? pc+imm : pc+INSN_BYTES.
- out_mispredict  out  1  out_taken != pred_taken, legal branches only.
- out_illegal  out  1  func3 is 010 or 011.
- out_misaligned  out  1  taken and target[1:0] != 0.
- taken_count  out  CNT_W  number of retired taken branches.
- mispredict_count  out  CNT_W  number of retired mispredicts.

Behaviour:
- Reset: when rst_n is low, all outputs and registers go to 0 asynchronously, including out_valid, both counters and out_redirect_pc.
- Handshake and latency:
  - Single-entry output register; in_ready = !out_valid || out_ready (combinational).
  - An input is accepted when in_valid && in_ready && !flush.
  - The result appears on the next rising edge; latency is exactly 1 cycle.
  - Back-to-back throughput is 1 per cycle while out_ready is high.
  - Output fields stay stable while out_valid && !out_ready.
- Compare:
  - 000: rs1 == rs2.
  - 001: rs1 != rs2.
  - 100: signed rs1 < rs2.
  - 101: signed rs1 >= rs2.
  - 110: unsigned rs1 < rs2.
  - 111: unsigned rs1 >= rs2.
  - 010/011: out_taken=0, out_illegal=1, out_mispredict=0, out_misaligned=0.
- Arithmetic:
  - target = pc + imm, truncated modulo 2^XLEN (wrap-around allowed, not flagged).
  - Fall-through = pc + INSN_BYTES, also modulo 2^XLEN.
- Flush:
  - Flush takes priority over everything else.
  - On the next edge, out_valid=0 and any same-cycle input is discarded.
  - The held result is discarded even when out_ready is high in that cycle.
  - Counters are not updated for the flushed result.
- Counters:
  - Update only on an output handshake (out_valid && out_ready && !flush).
  - taken_count += out_taken.
  - mispredict_count += out_mispredict.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Illegal results increment neither counter.
- Simultaneous events:
  - Output handshake and new input in the same cycle: the counter update uses the old result, and the register loads the new one.
- Mid-operation reset: the pending result is lost, counters clear, and in_ready becomes 1 once reset is released.

Decomposition:
- Shared package branch_pkg holds:
  - The func3 localparams BR_EQ=000, BR_NE=001, BR_LT=100, BR_GE=101, BR_LTU=110, BR_GEU=111.
  - A function is_legal_branch(func3).
- One combinational sub-module, branch_cmp:
  - Parametrised by XLEN.
  - Inputs rs1, rs2, func3; outputs cond, illegal.
  - branch_resolve_unit instantiates it and adds the registers, addresses and counters.

Test Plan:
- XLEN=32, rs1=-1, rs2=1, func3=100, pc=0x100, imm=0x20, pred_taken=0 -> one cycle later: out_taken=1, redirect=0x120, mispredict=1, mispredict_count=1 after the handshake.
- Same operands with func3=110 -> out_taken=0 (0xFFFFFFFF unsigned > 1), redirect=0x104, mispredict=0.
- func3=010, rs1=rs2=5, pred_taken=1 -> out_illegal=1, taken=0, mispredict=0, counters unchanged.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid high -> in_ready=0, output stable. Release -> one result per cycle with no loss or duplication across 4 branches.
- Flush in the same cycle as in_valid, with a result pending and out_ready=1 -> next cycle out_valid=0, counters unchanged. Then pc=0xFFFFFFF0, imm=0x12, func3=000, equal operands -> redirect=0x2, out_misaligned=1.
- CNT_W=2: retire 5 taken branches -> taken_count=3 (saturated). Assert rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
